// File: rtl/epu_pkg.sv
// epu_pkg: types and constants shared by the bias fetch controller and the
// bias SRAM wrapper.
//   bias_fetch_state_t : controller FSM state encoding
//   BIAS_ADDR_W        : bias SRAM word-address width (512 words)
//   BIAS_DATA_W        : bias word width
//   WRITE_DIS/ENB      : byte write-request encodings seen by the SRAM wrapper
package epu_pkg;

    localparam int BIAS_ADDR_W = 9;
    localparam int BIAS_DATA_W = 32;

    localparam logic [3:0] WRITE_DIS = 4'b0000;
    localparam logic [3:0] WRITE_ENB = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bias_fetch_state_t;

endpackage

// File: rtl/bias_fifo.sv
// bias_fifo: synchronous FIFO buffering bias words between the SRAM read
// path and the PE array.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous clear of all entries (used on job abort)
//   push/data  : write an entry
//   pop        : drop the head entry
//   head_data  : head entry, zero when empty
//   full/empty : occupancy flags
//   count      : number of stored entries
module bias_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count_q;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bias_fetch_ctrl.sv
// bias_fetch_ctrl: streams num_ch consecutive bias words, starting at
// base_addr, from the bias SRAM to the PE array over a valid/ready port.
//   clk, rst           : clock, synchronous active-high reset
//   start_i, abort_i   : job start (ignored while busy) / job cancel
//   base_addr_i        : first word address, sampled on start
//   num_ch_i           : word count 0..512, sampled on start
//   busy_o, done_o     : job in progress / one-cycle completion pulse
//   bias_valid_o/data_o/ready_i : output stream to the PE array
//   sram_cs_o/oe_o/addr_o/wreq_o : read-only SRAM master port
//   sram_rdata_i       : SRAM read data, one cycle after the addressed cycle
//
// state | meaning
// IDLE  | waiting for start_i
// FETCH | issuing reads, FIFO may be draining concurrently
// DRAIN | all reads issued, waiting for the array to take the last word
// DONE  | single-cycle completion, done_o high
module bias_fetch_ctrl
    import epu_pkg::*;
#(
    parameter int ADDR_W     = BIAS_ADDR_W,
    parameter int DATA_W     = BIAS_DATA_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   num_ch_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              bias_valid_o,
    output logic [DATA_W-1:0] bias_data_o,
    input  logic              bias_ready_i,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [3:0]        sram_wreq_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    bias_fetch_state_t state_q, state_d;

    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W:0]   num_ch_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   accepted_q;
    logic              inflight_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              pop;
    logic              start_accept;

    bias_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_i),
        .push      (inflight_q),
        .push_data (sram_rdata_i),
        .pop       (pop),
        .head_data (bias_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bias_valid_o = !fifo_empty;
    assign pop          = bias_valid_o && bias_ready_i;

    // Reserve a FIFO slot for every word still in flight; a pop in the same
    // cycle is deliberately not credited, so the FIFO can never overflow.
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
    assign issue     = (state_q == FETCH) && !abort_i && (issued_q < num_ch_q)
                       && !fifo_full && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign start_accept = (state_q == IDLE) && start_i && !abort_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_accept) state_d = (num_ch_i == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (abort_i) state_d = IDLE;
                else if (issue && (issued_q + (ADDR_W+1)'(1) == num_ch_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_i) state_d = IDLE;
                else if (fifo_empty && !inflight_q && (accepted_q == num_ch_q)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign sram_cs_o   = issue;
    assign sram_oe_o   = issue;
    assign sram_addr_o = issue ? rd_addr_q : last_addr_q;
    assign sram_wreq_o = WRITE_DIS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            last_addr_q <= '0;
            num_ch_q    <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            // An abort drops the word coming back from the SRAM this cycle.
            inflight_q <= issue && !abort_i;
            if (start_accept) begin
                rd_addr_q  <= base_addr_i;
                num_ch_q   <= num_ch_i;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                if (issue) begin
                    rd_addr_q   <= rd_addr_q + ADDR_W'(1);
                    last_addr_q <= rd_addr_q;
                    issued_q    <= issued_q + (ADDR_W+1)'(1);
                end
                if (pop) accepted_q <= accepted_q + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
module tb_bias_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [8:0]  base_addr_i = '0;
    logic [9:0]  num_ch_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        bias_valid_o;
    logic [31:0] bias_data_o;
    wire  logic  bias_ready_i;
    logic        sram_cs_o;
    logic        sram_oe_o;
    logic [8:0]  sram_addr_o;
    logic [3:0]  sram_wreq_o;
    logic [31:0] sram_rdata_i;

    logic ready_dir = 1'b1;
    logic rnd_mode  = 1'b0;
    logic rnd_bit   = 1'b0;
    assign bias_ready_i = rnd_mode ? rnd_bit : ready_dir;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    bit busy_seen = 0;

    logic [8:0]  issue_q[$];
    logic [31:0] beat_q[$];
    logic [31:0] mem [512];

    bias_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .base_addr_i  (base_addr_i),
        .num_ch_i     (num_ch_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bias_valid_o (bias_valid_o),
        .bias_data_o  (bias_data_o),
        .bias_ready_i (bias_ready_i),
        .sram_cs_o    (sram_cs_o),
        .sram_oe_o    (sram_oe_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wreq_o  (sram_wreq_o),
        .sram_rdata_i (sram_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input int a);
        return 32'hB1A5_0000 | 32'(a);
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = word_at(i);
    end

    // SRAM model: registered read, data one cycle after the addressed cycle.
    always @(posedge clk) begin
        if (sram_cs_o && sram_oe_o) sram_rdata_i <= mem[sram_addr_o];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (sram_cs_o) issue_q.push_back(sram_addr_o);
            if (bias_valid_o && bias_ready_i) beat_q.push_back(bias_data_o);
            if (done_o) done_cnt++;
            if (busy_o) busy_seen = 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic clear_obs();
        issue_q.delete();
        beat_q.delete();
        done_cnt  = 0;
        busy_seen = 0;
    endtask

    // Returns just after the accepting edge (#1), with the FSM in FETCH/DONE.
    task automatic start_job(input logic [8:0] b, input logic [9:0] n);
        @(posedge clk);
        #1;
        base_addr_i = b;
        num_ch_i    = n;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic compare_stream(input string tag, input logic [8:0] b, input int n);
        logic [8:0] ea;
        check({tag, "_n_issue"}, 32'(issue_q.size()), 32'(n));
        check({tag, "_n_beat"}, 32'(beat_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            ea = 9'(int'(b) + i);
            if (i < issue_q.size()) check($sformatf("%s_addr%0d", tag, i), 32'(issue_q[i]), 32'(ea));
            if (i < beat_q.size())  check($sformatf("%s_data%0d", tag, i), beat_q[i], word_at(int'(ea)));
        end
    endtask

    initial begin
        int cnt_before;
        bit reached;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_valid", 32'(bias_valid_o), 32'd0);
        check("rst_data", bias_data_o, 32'd0);
        check("rst_cs", 32'(sram_cs_o), 32'd0);
        check("rst_oe", 32'(sram_oe_o), 32'd0);
        check("rst_addr", 32'(sram_addr_o), 32'd0);
        check("rst_wreq", 32'(sram_wreq_o), 32'd0);
        rst = 1'b0;

        // T1: basic stream, first-beat latency
        clear_obs();
        ready_dir = 1'b1;
        start_job(9'h010, 10'd4);
        check("t1_cs_first", 32'(sram_cs_o), 32'd1);
        check("t1_oe_first", 32'(sram_oe_o), 32'd1);
        check("t1_addr_first", 32'(sram_addr_o), 32'h010);
        check("t1_busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        check("t1_valid_early", 32'(bias_valid_o), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_rise", 32'(bias_valid_o), 32'd1);
        check("t1_data_first", bias_data_o, word_at(9'h010));
        wait_done("t1", 100);
        @(posedge clk); #1;
        check("t1_busy_after", 32'(busy_o), 32'd0);
        check("t1_done_after", 32'(done_o), 32'd0);
        compare_stream("t1", 9'h010, 4);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);

        // T2: address wrap 0x1FF -> 0x000
        clear_obs();
        start_job(9'h1FE, 10'd4);
        wait_done("t2", 100);
        @(posedge clk); #1;
        compare_stream("t2", 9'h1FE, 4);

        // T3: back-pressure limits outstanding reads to the FIFO depth
        clear_obs();
        ready_dir = 1'b0;
        start_job(9'h080, 10'd8);
        repeat (10) @(posedge clk);
        #1;
        check("t3_n_issue_stall", 32'(issue_q.size()), 32'd2);
        check("t3_cs_stall", 32'(sram_cs_o), 32'd0);
        check("t3_valid_stall", 32'(bias_valid_o), 32'd1);
        check("t3_data_stall", bias_data_o, word_at(9'h080));
        ready_dir = 1'b1;
        wait_done("t3", 200);
        @(posedge clk); #1;
        compare_stream("t3", 9'h080, 8);

        // T4: zero-length job
        clear_obs();
        start_job(9'h020, 10'd0);
        check("t4_done", 32'(done_o), 32'd1);
        check("t4_busy", 32'(busy_o), 32'd0);
        check("t4_cs", 32'(sram_cs_o), 32'd0);
        @(posedge clk); #1;
        check("t4_done_drop", 32'(done_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_n_issue", 32'(issue_q.size()), 32'd0);
        check("t4_busy_seen", 32'(busy_seen), 32'd0);
        check("t4_done_cnt", 32'(done_cnt), 32'd1);

        // T5: abort after 5 accepted beats, then a clean job
        clear_obs();
        start_job(9'h100, 10'd16);
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk);
            if (beat_q.size() >= 5) reached = 1;
        end
        check("t5_reach5", 32'(reached), 32'd1);
        #1;
        abort_i   = 1'b1;
        ready_dir = 1'b0;
        @(posedge clk); #1;
        abort_i = 1'b0;
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_valid", 32'(bias_valid_o), 32'd0);
        check("t5_cs", 32'(sram_cs_o), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_valid_later", 32'(bias_valid_o), 32'd0);
        check("t5_no_done", 32'(done_cnt), 32'd0);
        check("t5_n_beat", 32'(beat_q.size()), 32'd5);
        clear_obs();
        ready_dir = 1'b1;
        start_job(9'h040, 10'd2);
        wait_done("t5b", 100);
        @(posedge clk); #1;
        compare_stream("t5b", 9'h040, 2);

        // T6: 512 words with random back-pressure; a second start mid-job is ignored
        clear_obs();
        rnd_mode = 1'b1;
        start_job(9'h000, 10'd512);
        repeat (20) @(posedge clk);
        #1;
        base_addr_i = 9'h123;
        num_ch_i    = 10'd3;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cnt_before = beat_q.size();
        check("t6_busy_mid", 32'(busy_o), 32'd1);
        wait_done("t6", 8000);
        @(posedge clk); #1;
        rnd_mode = 1'b0;
        compare_stream("t6", 9'h000, 512);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_not_finished_early", 32'(cnt_before < 512), 32'd1);

        // T7: reset in the middle of a job
        clear_obs();
        ready_dir = 1'b0;
        start_job(9'h0F0, 10'd8);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t7_cs", 32'(sram_cs_o), 32'd0);
        check("t7_busy", 32'(busy_o), 32'd0);
        check("t7_valid", 32'(bias_valid_o), 32'd0);
        check("t7_addr", 32'(sram_addr_o), 32'd0);
        check("t7_data", bias_data_o, 32'd0);
        ready_dir = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
